// File: rtl/mmio_pkg.sv
// Shared constants for the memory-mapped seven-segment display.
// Segment codes are active-low, ordered {g,f,e,d,c,b,a}.
package mmio_pkg;

    localparam logic [6:0] MMIO_ADDR_DEF = 7'h7F;
    localparam logic [6:0] SEG_BLANK     = 7'b1111111;
    localparam int         NUM_DIGITS    = 4;

    // Element [n] is the glyph for hex nibble n; lowercase b and d.
    localparam logic [15:0][6:0] SEG_HEX = {
        7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
        7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
        7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
        7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };

endpackage

// File: rtl/mmio_seg_display_hex7seg.sv
// Combinational nibble to active-low seven-segment code.
module hex7seg
    import mmio_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_HEX[nib_i];

endmodule

// File: rtl/mmio_seg_display.sv
// Snoops CPU stores to one word address and scans it onto a 4-digit display.
// Optional leading-zero blanking: define DISP_BLANK_LEADING_EN.
module mmio_seg_display
    import mmio_pkg::*;
#(
    parameter logic [6:0]  MMIO_ADDR   = MMIO_ADDR_DEF,
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CS,
    input  logic        WE,
    input  logic [6:0]  ADDR,
    input  logic [31:0] DATA_IN,
    input  logic        SEL,
    output logic [3:0]  AN,
    output logic [6:0]  SEG,
    output logic        DP,
    output logic        UPD
);

    localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

    logic [31:0]   dval_q, dval_d;
    logic          upd_q, upd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    dig_q, dig_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;

    logic        wr_hit;
    logic        wrap;
    logic [15:0] half;
    logic [3:0]  nib;
    logic [6:0]  hex;
    logic        blank;

    assign wr_hit = CS & WE & (ADDR == MMIO_ADDR);
    assign wrap   = (cnt_q == CNT_MAX);

    always_comb begin
        dval_d = wr_hit ? DATA_IN : dval_q;
        upd_d  = wr_hit;
        cnt_d  = wrap ? '0 : cnt_q + 1'b1;
        dig_d  = wrap ? dig_q + 2'd1 : dig_q;
    end

    assign half = SEL ? dval_q[31:16] : dval_q[15:0];
    assign nib  = half[{dig_q, 2'b00} +: 4];

    hex7seg u_hex (
        .nib_i (nib),
        .seg_o (hex)
    );

`ifdef DISP_BLANK_LEADING_EN
    logic [1:0] msd;

    // Highest nonzero nibble; digit 0 stays lit even for zero.
    always_comb begin
        msd = '0;
        for (int i = 1; i < NUM_DIGITS; i++) begin
            if (half[4*i +: 4] != 4'h0) msd = 2'(i);
        end
    end

    assign blank = (dig_q > msd);
`else
    assign blank = 1'b0;
`endif

    always_comb begin
        an_d  = blank ? 4'b1111 : ~(4'b0001 << dig_q);
        seg_d = blank ? SEG_BLANK : hex;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            dval_q <= '0;
            upd_q  <= 1'b0;
            cnt_q  <= '0;
            dig_q  <= '0;
            an_q   <= 4'b1110;
            seg_q  <= 7'b1000000;
        end else begin
            dval_q <= dval_d;
            upd_q  <= upd_d;
            cnt_q  <= cnt_d;
            dig_q  <= dig_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
        end
    end

    assign AN  = an_q;
    assign SEG = seg_q;
    assign DP  = 1'b1;
    assign UPD = upd_q;

endmodule

// File: tb/tb_mmio_seg_display.sv
// Scoreboard bench for mmio_seg_display with a 4-cycle digit slot.
module tb_mmio_seg_display;

    localparam int DIV = 4;

    localparam logic [15:0][6:0] SEGT = {
        7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
        7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
        7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
        7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       upd;
    } exp_t;

    logic        CLK, RST, CS, WE, SEL;
    logic [6:0]  ADDR;
    logic [31:0] DATA_IN;
    logic [3:0]  AN;
    logic [6:0]  SEG;
    logic        DP, UPD;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t        q[$];
    int          m_n;
    logic [31:0] m_dval;

    mmio_seg_display #(.MMIO_ADDR(7'h7F), .REFRESH_DIV(DIV)) dut (
        .CLK(CLK), .RST(RST), .CS(CS), .WE(WE), .ADDR(ADDR),
        .DATA_IN(DATA_IN), .SEL(SEL), .AN(AN), .SEG(SEG),
        .DP(DP), .UPD(UPD)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic bus(input logic cs, input logic we,
                       input logic [6:0] a, input logic [31:0] d);
        CS = cs; WE = we; ADDR = a; DATA_IN = d;
    endtask

    // One clock: predict at the edge, compare at the following negedge.
    task automatic step();
        exp_t        e;
        logic [15:0] hw;
        logic [3:0]  one;
        int          d;
        int          msd;
        logic        cap;
        @(posedge CLK);
        one = 4'b0001;
        cap = CS && WE && (ADDR == 7'h7F);
        hw  = SEL ? m_dval[31:16] : m_dval[15:0];
        d   = (m_n / DIV) % 4;
        e.an  = ~(one << d);
        e.seg = SEGT[hw[4*d +: 4]];
        e.upd = cap;
        msd = 0;
        for (int i = 0; i < 4; i++) if (hw[4*i +: 4] != 4'h0) msd = i;
`ifdef DISP_BLANK_LEADING_EN
        if (d > msd) begin
            e.an  = 4'b1111;
            e.seg = 7'b1111111;
        end
`endif
        q.push_back(e);
        if (cap) m_dval = DATA_IN;
        m_n++;
        @(negedge CLK);
        e = q.pop_front();
        n_checks++;
        if (AN !== e.an) begin
            n_fail++;
            $display("FAIL an t=%0t got %b exp %b", $time, AN, e.an);
        end
        n_checks++;
        if (SEG !== e.seg) begin
            n_fail++;
            $display("FAIL seg t=%0t got %b exp %b", $time, SEG, e.seg);
        end
        n_checks++;
        if (UPD !== e.upd) begin
            n_fail++;
            $display("FAIL upd t=%0t got %b exp %b", $time, UPD, e.upd);
        end
        n_checks++;
        if (DP !== 1'b1) begin
            n_fail++;
            $display("FAIL dp t=%0t got %b exp 1", $time, DP);
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic chk_reset_outs(input string nm);
        n_checks++;
        if ({AN, SEG, DP, UPD} !== {4'b1110, 7'b1000000, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL %s got an=%b seg=%b dp=%b upd=%b exp 1110 1000000 1 0",
                     nm, AN, SEG, DP, UPD);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1; SEL = 1'b0;
        bus(0, 0, 7'h00, 32'h0);
        #1;
        chk_reset_outs("reset_init");
        @(negedge CLK);
        RST = 1'b0;
        m_n = 0; m_dval = '0;
        steps(8);
    endtask

    task automatic test_write();
        bus(1, 1, 7'h7F, 32'hABCD_1234);
        step();
        bus(0, 0, 7'h00, 32'h0);
        steps(20);
    endtask

    task automatic test_nonmatch();
        bus(1, 1, 7'h10, 32'hDEAD_BEEF);
        step();
        bus(1, 0, 7'h7F, 32'h5A5A_5A5A);
        step();
        bus(0, 1, 7'h7F, 32'h7777_7777);
        step();
        bus(0, 0, 7'h00, 32'h0);
        steps(16);
    endtask

    task automatic test_sel();
        SEL = 1'b1;
        steps(17);
        SEL = 1'b0;
        steps(3);
    endtask

    task automatic test_back_to_back();
        bus(1, 1, 7'h7F, 32'h1111_1111);
        step();
        bus(1, 1, 7'h7F, 32'h2222_2222);
        step();
        bus(0, 0, 7'h00, 32'h0);
        steps(16);
    endtask

    task automatic test_wrap_capture();
        while ((m_n % 16) != 15) step();
        bus(1, 1, 7'h7F, 32'h5555_9876);
        step();
        bus(0, 0, 7'h00, 32'h0);
        step();
        n_checks++;
        if (AN !== 4'b1110 || SEG !== 7'b0000010) begin
            n_fail++;
            $display("FAIL wrap_capture got an=%b seg=%b exp 1110 0000010", AN, SEG);
        end
        steps(15);
    endtask

    task automatic test_reset_mid();
        bus(1, 1, 7'h7F, 32'h0000_00F0);
        step();
        bus(0, 0, 7'h00, 32'h0);
        #2;
        RST = 1'b1;
        #1;
        chk_reset_outs("reset_mid");
        @(negedge CLK);
        chk_reset_outs("reset_hold");
        RST = 1'b0;
        m_n = 0; m_dval = '0;
        steps(18);
    endtask

    task automatic test_blank();
        bus(1, 1, 7'h7F, 32'h0000_0012);
        step();
        bus(0, 0, 7'h00, 32'h0);
        steps(17);
        bus(1, 1, 7'h7F, 32'h0000_0000);
        step();
        bus(0, 0, 7'h00, 32'h0);
        steps(17);
        bus(1, 1, 7'h7F, 32'h0300_0000);
        step();
        bus(0, 0, 7'h00, 32'h0);
        SEL = 1'b1;
        steps(17);
        SEL = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write();
        test_nonmatch();
        test_sel();
        test_back_to_back();
        test_wrap_capture();
        test_reset_mid();
        test_blank();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
